// File: rtl/nibble_adder_pkg.sv
// ---------------------------------------------------------------------------
// nibble_adder_pkg
// Shared definitions for the nibble-serial adder: controller state encoding,
// the slice width, and a helper that gives the nibble count for a width.
// ---------------------------------------------------------------------------
package nibble_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int nib_count(input int width);
        return width / NIBBLE_W;
    endfunction

endpackage

// File: rtl/nibble_add_slice.sv
// ---------------------------------------------------------------------------
// nibble_add_slice
// 4-bit ripple-carry adder built from full-adder stages.
// Ports:
//   a, b  : nibble operands
//   cin   : carry into bit 0
//   sum   : nibble sum
//   cout  : carry out of bit 3
// ---------------------------------------------------------------------------
module nibble_add_slice
    import nibble_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    logic [NIBBLE_W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder_ctrl
// Computes a WIDTH-bit add one nibble per clock (LSB first) through a single
// shared 4-bit ripple slice, holding the inter-nibble carry in a register.
// Valid/ready handshakes on the operand and result sides.
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : operand handshake (accepted only in IDLE)
//   in_a, in_b, in_cin    : operands and carry-in to nibble 0
//   in_sub                : (NIBBLE_SERIAL_ADDER_SUB_EN only) compute A-B
//   out_valid / out_ready : result handshake (held in DONE)
//   out_sum, out_cout     : result and carry out of bit WIDTH-1
//   busy                  : high while in RUN or DONE
//
// Build option: define NIBBLE_SERIAL_ADDER_SUB_EN to add the in_sub port.
// With in_sub=1, B is inverted and carry-in forced to 1 (two's complement),
// so out_cout=1 means no borrow.
// ---------------------------------------------------------------------------
module nibble_serial_adder_ctrl
    import nibble_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);

    localparam int NIB   = nib_count(WIDTH);
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_DONE = DONE;

    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
        $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and at least 4");
    end

    logic [1:0]          state;
    logic [IDX_W-1:0]    idx;
    logic                carry;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;

    logic                accept;
    logic [WIDTH-1:0]    b_init;
    logic                cin_init;

    logic [NIBBLE_W-1:0] a_nib;
    logic [NIBBLE_W-1:0] b_nib;
    logic [NIBBLE_W-1:0] slice_sum;
    logic                slice_cout;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign accept    = in_valid && in_ready;

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    // Subtraction as A + ~B + 1: invert B at capture, force carry-in high.
    assign b_init   = in_sub ? ~in_b : in_b;
    assign cin_init = in_sub ? 1'b1  : in_cin;
`else
    assign b_init   = in_b;
    assign cin_init = in_cin;
`endif

    // Operands are captured only at accept, so in_valid/in_a/in_b are
    // ignored for the rest of the operation. No reset needed: they are
    // always written before being read.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= in_a;
            b_q <= b_init;
        end
    end

    assign a_nib = a_q[idx*NIBBLE_W +: NIBBLE_W];
    assign b_nib = b_q[idx*NIBBLE_W +: NIBBLE_W];

    nibble_add_slice u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            idx      <= '0;
            carry    <= 1'b0;
            out_sum  <= '0;
            out_cout <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        carry   <= cin_init;
                        idx     <= '0;
                        out_sum <= '0;
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    out_sum[idx*NIBBLE_W +: NIBBLE_W] <= slice_sum;
                    carry <= slice_cout;
                    idx   <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        out_cout <= slice_cout;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nibble_serial_adder_ctrl
// Self-checking bench: a transaction-level model predicts the handshake
// outputs and the result each cycle; directed cases pin literal results.
// ---------------------------------------------------------------------------
module tb_nibble_serial_adder_ctrl;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic             in_cin = 1'b0;
    logic             in_sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: cycles elapsed since acceptance (0 = idle). Result is just
    // the arithmetic sum, ready once NIB edges have passed since accept.
    // ------------------------------------------------------------------
    int               m_age = 0;
    logic [WIDTH:0]   m_res = '0;

    function automatic logic [WIDTH:0] model_result(input logic [WIDTH-1:0] a,
                                                     input logic [WIDTH-1:0] b,
                                                     input logic cin, input logic sub);
        logic [WIDTH:0] r;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        if (sub) r = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        else     r = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
`else
        r = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
        if (sub) r = r;
`endif
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_age <= 0;
        end else if (m_age == 0) begin
            if (in_valid) begin
                m_res <= model_result(in_a, in_b, in_cin, in_sub);
                m_age <= 1;
            end
        end else if (m_age < NIB) begin
            m_age <= m_age + 1;
        end else if (m_age == NIB) begin
            m_age <= NIB + 1;
        end else if (out_ready) begin
            m_age <= 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready",  64'(in_ready),  64'(m_age == 0));
            check("busy",      64'(busy),      64'(m_age != 0));
            check("out_valid", 64'(out_valid), 64'(m_age == NIB + 1));
            if (m_age == NIB + 1) begin
                check("out_sum",  64'(out_sum),  64'(m_res[WIDTH-1:0]));
                check("out_cout", 64'(out_cout), 64'(m_res[WIDTH]));
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver: present one operation, optional noise on the input side
    // while busy, hold backpressure for 'hold' cycles, then drain.
    // ------------------------------------------------------------------
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, input logic sub, input int hold, input bit noise,
                         output logic [WIDTH-1:0] sum, output logic cout, output int lat);
        int cyc;
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_sub = sub;
        @(negedge clk);
        in_valid = noise;
        cyc = 0;
        while (!out_valid && cyc < 64) begin
            if (noise) begin
                in_a = WIDTH'($urandom); in_b = WIDTH'($urandom);
                in_cin = 1'($urandom); in_sub = 1'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        lat = cyc;
        if (cyc >= 64) check("timeout", 64'(cyc), 64'(NIB));
        sum = out_sum; cout = out_cout;
        for (int i = 0; i < hold; i++) @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    logic [WIDTH-1:0] s;
    logic             co;
    int               lat;

    initial begin
        #12;
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_out_sum",   64'(out_sum),   64'd0);
        check("rst_out_cout",  64'(out_cout),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(16'h0001, 16'h0006, 1'b0, 1'b0, 0, 1'b0, s, co, lat);
        check("simple_sum",  64'(s),   64'h0007);
        check("simple_cout", 64'(co),  64'd0);
        check("simple_lat",  64'(lat), 64'(NIB));

        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, s, co, lat);
        check("chain1_sum",  64'(s),  64'h0000);
        check("chain1_cout", 64'(co), 64'd1);

        do_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1, 1'b0, s, co, lat);
        check("chain2_sum",  64'(s),  64'hFFFF);
        check("chain2_cout", 64'(co), 64'd1);

        // Backpressure: compare process verifies stability for every held cycle.
        do_op(16'h8000, 16'h9000, 1'b0, 1'b0, 10, 1'b0, s, co, lat);
        check("bp_sum",  64'(s),  64'h1000);
        check("bp_cout", 64'(co), 64'd1);
        #1;
        check("bp_idle_ready", 64'(in_ready), 64'd1);

        // Busy ignore: noise on the operand side during RUN/DONE.
        do_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 2, 1'b1, s, co, lat);
        check("ignore_sum",  64'(s),  64'h1000);
        check("ignore_cout", 64'(co), 64'd0);

        // Reset after two nibble edges of RUN.
        @(negedge clk);
        in_valid = 1'b1; in_a = 16'hABCD; in_b = 16'h1357; in_cin = 1'b1; in_sub = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready",  64'(in_ready),  64'd1);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_busy",      64'(busy),      64'd0);
        check("mid_rst_out_sum",   64'(out_sum),   64'd0);
        check("mid_rst_out_cout",  64'(out_cout),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(16'h1234, 16'h1111, 1'b0, 1'b0, 0, 1'b0, s, co, lat);
        check("post_rst_sum",  64'(s),  64'h2345);
        check("post_rst_cout", 64'(co), 64'd0);

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0, 1'b0, s, co, lat);
        check("sub1_sum",  64'(s),  64'hFFFE);
        check("sub1_cout", 64'(co), 64'd0);
        do_op(16'h0007, 16'h0005, 1'b0, 1'b1, 0, 1'b0, s, co, lat);
        check("sub2_sum",  64'(s),  64'h0002);
        check("sub2_cout", 64'(co), 64'd1);
`endif

        // Randomized traffic; correctness checked by the model every cycle.
        for (int k = 0; k < 40; k++) begin
            logic sub_r;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
            sub_r = 1'($urandom);
`else
            sub_r = 1'b0;
`endif
            do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), sub_r,
                  int'($urandom_range(0, 3)), bit'($urandom), s, co, lat);
            check("rand_lat", 64'(lat), 64'(NIB));
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got time %0t expected finish", $time);
        $fatal(1, "watchdog");
    end

endmodule
